// File: rtl/button_conditioner_if.sv
// button_conditioner_if
//   Bundles the four raw push-button levels and the four conditioned
//   single-cycle command pulses of the clock's input front end.
//   Ports (signals):
//     mode_btn, set_btn, op1_btn, op2_btn : raw asynchronous button levels, active-high
//     mode, set, op1, op2                 : one-cycle command pulses to the clock core
//   Modports:
//     master : drives the raw buttons, observes the pulses (button side / bench)
//     slave  : samples the raw buttons, drives the pulses (button_conditioner)
interface button_conditioner_if;
  logic mode_btn;
  logic set_btn;
  logic op1_btn;
  logic op2_btn;
  logic mode;
  logic set;
  logic op1;
  logic op2;

  modport master (
    output mode_btn, set_btn, op1_btn, op2_btn,
    input  mode, set, op1, op2
  );

  modport slave (
    input  mode_btn, set_btn, op1_btn, op2_btn,
    output mode, set, op1, op2
  );
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner
//   Turns the four raw push-buttons of the digital clock into clean,
//   single-cycle command pulses. Per button: two-flop synchronizer,
//   debounce counter producing a stable level, rising-edge detect.
//   op1/op2 add hold-to-repeat. At most one pulse is issued per cycle,
//   priority mode > set > op1 > op2; losing requests are dropped.
//   Ports:
//     clk    : system clock, rising edge
//     reset  : synchronous, active-high
//     btn_if : slave side of button_conditioner_if (raw buttons in, pulses out)
//   Parameters:
//     DEBOUNCE_CYCLES : cycles a level must persist before it is accepted
//     REPEAT_DELAY    : cycles from press pulse to first auto-repeat pulse
//     REPEAT_PERIOD   : cycles between later auto-repeat pulses
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 4
) (
  input logic            clk,
  input logic            reset,
  button_conditioner_if.slave btn_if
);

  localparam int DBW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPW    = $clog2(RMAX + 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rep_state_t;

  // Bit order everywhere: [0]=mode, [1]=set, [2]=op1, [3]=op2 (also priority order).
  logic [3:0]     raw;
  logic [3:0]     sync_p0;
  logic [3:0]     sync_p1;
  logic [3:0]     stable_p2;
  logic [3:0]     stable_d_p3;
  logic [DBW-1:0] db_cnt [4];
  logic [3:0]     press;
  logic [1:0]     rep_req;
  logic [3:0]     req;
  logic [3:0]     grant;
  logic [3:0]     pulse_p4;

  assign raw = {btn_if.op2_btn, btn_if.op1_btn, btn_if.set_btn, btn_if.mode_btn};

  // Stage p0/p1: synchronizer; stage p2: debounced level; p3: previous level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0     <= '0;
      sync_p1     <= '0;
      stable_p2   <= '0;
      stable_d_p3 <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0     <= raw;
      sync_p1     <= sync_p0;
      stable_d_p3 <= stable_p2;
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] == stable_p2[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          // This cycle is the DEBOUNCE_CYCLES-th consecutive mismatch.
          stable_p2[i] <= sync_p1[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  assign press = stable_p2 & ~stable_d_p3;

  // Hold-to-repeat for op1 (j=0) and op2 (j=1).
  for (genvar j = 0; j < 2; j++) begin : g_rep
    rep_state_t     state;
    logic [RPW-1:0] cnt;

    // Counter value 1 marks expiry; a falling stable level takes precedence.
    assign rep_req[j] = (state != IDLE) && stable_p2[j+2] && (cnt == RPW'(1));

    always_ff @(posedge clk) begin
      if (reset) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (press[j+2]) begin
              state <= HOLD;
              cnt   <= RPW'(REPEAT_DELAY);
            end
          end
          HOLD, REPEAT: begin
            if (!stable_p2[j+2]) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == RPW'(1)) begin
              // Advances whether or not arbitration granted this request.
              state <= REPEAT;
              cnt   <= RPW'(REPEAT_PERIOD);
            end else begin
              cnt <= cnt - RPW'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign req = press | {rep_req, 2'b00};

  always_comb begin
    grant = '0;
    if (req[0])      grant[0] = 1'b1;
    else if (req[1]) grant[1] = 1'b1;
    else if (req[2]) grant[2] = 1'b1;
    else if (req[3]) grant[3] = 1'b1;
  end

  // Stage p4: registered one-hot command pulse
  always_ff @(posedge clk) begin
    if (reset) pulse_p4 <= '0;
    else       pulse_p4 <= grant;
  end

  assign btn_if.mode = pulse_p4[0];
  assign btn_if.set  = pulse_p4[1];
  assign btn_if.op1  = pulse_p4[2];
  assign btn_if.op2  = pulse_p4[3];

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
//   Directed bench for button_conditioner with default parameters.
//   Edge e of a scenario is the e-th rising edge after the scenario starts;
//   inputs for edge e are applied 1 time unit after edge e-1, and outputs
//   {mode,set,op1,op2} are observed 1 time unit after edge e.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vecs = 0;
  int   fails = 0;

  button_conditioner_if bif ();

  button_conditioner dut (
    .clk    (clk),
    .reset  (reset),
    .btn_if (bif)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    bif.mode_btn = 1'b0;
    bif.set_btn  = 1'b0;
    bif.op1_btn  = 1'b0;
    bif.op2_btn  = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // All buttons high through 3 reset edges; one mode pulse 7 edges after the
  // last reset edge (first sampled-high edge is 3, pulse follows edge 9).
  task automatic test_reset();
    logic [3:0] got, exp;
    for (int e = 0; e < 40; e++) begin
      reset        = (e < 3);
      bif.mode_btn = (e < 12);
      bif.set_btn  = (e < 12);
      bif.op1_btn  = (e < 12);
      bif.op2_btn  = (e < 12);
      @(posedge clk); #1;
      got = {bif.mode, bif.set, bif.op1, bif.op2};
      exp = (e == 9) ? 4'b1000 : 4'b0000;
      vecs++;
      if (got !== exp) begin
        fails++;
        $display("FAIL reset e=%0d got=%b exp=%b", e, got, exp);
      end
    end
    reset = 1'b0;
  endtask

  // op1 high on edges 10..19: single pulse after edge 16, nothing on release.
  task automatic test_clean_press();
    logic [3:0] got, exp;
    do_reset();
    for (int e = 0; e < 40; e++) begin
      bif.op1_btn = (e >= 10 && e < 20);
      @(posedge clk); #1;
      got = {bif.mode, bif.set, bif.op1, bif.op2};
      exp = (e == 16) ? 4'b0010 : 4'b0000;
      vecs++;
      if (got !== exp) begin
        fails++;
        $display("FAIL clean_press e=%0d got=%b exp=%b", e, got, exp);
      end
    end
  endtask

  // set: high 3, low 2, high 3, low -> never 4 consecutive mismatches.
  task automatic test_glitch();
    logic [3:0] got, exp;
    do_reset();
    for (int e = 0; e < 30; e++) begin
      bif.set_btn = (e < 3) || (e >= 5 && e < 8);
      @(posedge clk); #1;
      got = {bif.mode, bif.set, bif.op1, bif.op2};
      exp = 4'b0000;
      vecs++;
      if (got !== exp) begin
        fails++;
        $display("FAIL glitch e=%0d got=%b exp=%b", e, got, exp);
      end
    end
  endtask

  // op2 high on edges 0..35: release sampled at 36, stable falls at edge 41,
  // so the expiry due at edge 42 is suppressed.
  task automatic test_auto_repeat();
    logic [3:0] got, exp;
    do_reset();
    for (int e = 0; e < 60; e++) begin
      bif.op2_btn = (e < 36);
      @(posedge clk); #1;
      got = {bif.mode, bif.set, bif.op1, bif.op2};
      exp = (e == 6 || e == 22 || e == 26 || e == 30 || e == 34 || e == 38)
            ? 4'b0001 : 4'b0000;
      vecs++;
      if (got !== exp) begin
        fails++;
        $display("FAIL auto_repeat e=%0d got=%b exp=%b", e, got, exp);
      end
    end
  endtask

  // mode and op1 rise together: mode wins at 6, op1 dropped but its FSM
  // still repeats at 22. Release sampled at 20 -> stable low before 26.
  task automatic test_simultaneous();
    logic [3:0] got, exp;
    do_reset();
    for (int e = 0; e < 40; e++) begin
      bif.mode_btn = (e < 20);
      bif.op1_btn  = (e < 20);
      @(posedge clk); #1;
      got = {bif.mode, bif.set, bif.op1, bif.op2};
      exp = (e == 6) ? 4'b1000 : (e == 22) ? 4'b0010 : 4'b0000;
      vecs++;
      if (got !== exp) begin
        fails++;
        $display("FAIL simultaneous e=%0d got=%b exp=%b", e, got, exp);
      end
    end
  endtask

  // set held 50 cycles: exactly one pulse.
  task automatic test_hold_nonrepeat();
    logic [3:0] got, exp;
    do_reset();
    for (int e = 0; e < 70; e++) begin
      bif.set_btn = (e < 50);
      @(posedge clk); #1;
      got = {bif.mode, bif.set, bif.op1, bif.op2};
      exp = (e == 6) ? 4'b0100 : 4'b0000;
      vecs++;
      if (got !== exp) begin
        fails++;
        $display("FAIL hold_nonrepeat e=%0d got=%b exp=%b", e, got, exp);
      end
    end
  endtask

  // Reset mid-debounce (op1) and mid-hold (op2) aborts with no later pulse.
  task automatic test_reset_abort();
    logic [3:0] got, exp;
    do_reset();
    for (int e = 0; e < 30; e++) begin
      bif.op1_btn = (e < 4);
      reset       = (e == 3 || e == 4);
      @(posedge clk); #1;
      got = {bif.mode, bif.set, bif.op1, bif.op2};
      exp = 4'b0000;
      vecs++;
      if (got !== exp) begin
        fails++;
        $display("FAIL abort_debounce e=%0d got=%b exp=%b", e, got, exp);
      end
    end
    do_reset();
    for (int e = 0; e < 40; e++) begin
      bif.op2_btn = (e < 20);
      reset       = (e == 20 || e == 21);
      @(posedge clk); #1;
      got = {bif.mode, bif.set, bif.op1, bif.op2};
      exp = (e == 6) ? 4'b0001 : 4'b0000;
      vecs++;
      if (got !== exp) begin
        fails++;
        $display("FAIL abort_repeat e=%0d got=%b exp=%b", e, got, exp);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    bif.mode_btn = 1'b0;
    bif.set_btn  = 1'b0;
    bif.op1_btn  = 1'b0;
    bif.op2_btn  = 1'b0;
    #1;
    test_reset();
    test_clean_press();
    test_glitch();
    test_auto_repeat();
    test_simultaneous();
    test_hold_nonrepeat();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
